// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
//   state_t          : loader FSM states
//   PREAMBLE_DEFAULT : pattern shifted ahead of the payload, checked on the tail
//   nbytes()         : bytes needed to cover a chain of the given length
package ccff_pkg;

  typedef enum logic [2:0] {IDLE, PRE, PAY, DONE, ERR} state_t;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'hA5;

  function automatic int nbytes(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Byte input bus plus serial chain connection of the loader.
//   cfg_data/cfg_valid/cfg_ready : byte stream, MSB shifted first
//   ccff_head/ccff_en            : serial data and shift enable into the chain
//   ccff_tail                    : last flop of the chain, back to the loader
// slave  = loader side, master = bitstream source / chain side.
interface ccff_loader_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       ccff_head;
  logic       ccff_en;
  logic       ccff_tail;

  modport slave (
    input  cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_en
  );

  modport master (
    output cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_en
  );
endinterface

// File: rtl/ccff_byte_serializer.sv
// One-byte buffer that turns accepted bytes into an MSB-first bit stream.
//   clk, rst     : clock, async active-high reset
//   clr          : synchronous flush (new load)
//   en           : byte acceptance allowed at all
//   data/valid/ready : byte input; ready only when the buffer is empty
//   pop          : consume the current bit
//   sbit/has_bit : current bit and whether one is available
module ccff_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       pop,
  output logic       sbit,
  output logic       has_bit
);
  logic [7:0] buf_q;
  logic [3:0] fill_q;

  assign ready   = en && (fill_q == 4'd0);
  assign sbit    = buf_q[7];
  assign has_bit = (fill_q != 4'd0);

  // Load and pop are mutually exclusive: load needs fill==0, pop needs fill!=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (clr) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (valid && ready) begin
      buf_q  <= data;
      fill_q <= 4'd8;
    end else if (pop && has_bit) begin
      buf_q  <= {buf_q[6:0], 1'b0};
      fill_q <= fill_q - 4'd1;
    end
  end
endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: shifts PREAMBLE then CHAIN_LEN payload bits into
// the chain head, and checks that the preamble re-emerges on the chain tail.
//   prog_clk, prog_reset : clock, async active-high reset
//   start                : begin a load (ignored while busy)
//   bus                  : byte input + chain head/enable/tail
//   busy / done / error  : load in progress / verified / preamble mismatch
// PRE_LEN must be 8.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int         CHAIN_LEN = 23,
  parameter int         PRE_LEN   = 8,
  parameter logic [7:0] PREAMBLE  = PREAMBLE_DEFAULT
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         start,
  ccff_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error
);
  localparam int TOTAL = CHAIN_LEN + PRE_LEN;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOT_C = CW'(TOTAL);
  localparam logic [CW-1:0] CL_C  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] PL_C  = CW'(PRE_LEN);
  localparam logic [CW-1:0] NB_C  = CW'(nbytes(CHAIN_LEN));

  state_t        state_q, state_d;
  logic [CW-1:0] icnt_q;   // bits issued onto ccff_head
  logic [CW-1:0] scnt_q;   // shifts actually taken by the chain
  logic [CW-1:0] acc_q;    // bytes accepted
  logic          mism_q;
  logic          start_go, shift_edge, last_shift, tail_bad, xfer;
  logic          en_d, head_d, pop, ser_bit, has_bit;
  logic [2:0]    tail_idx;

  assign start_go   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  // ccff_en is registered, so a high value now means the chain shifts at this edge.
  assign shift_edge = bus.ccff_en;
  assign last_shift = shift_edge && (scnt_q == TOT_C - 1'b1);
  // Tail at shift s carries bit s-CHAIN_LEN, i.e. the preamble for the final 8 shifts.
  assign tail_idx   = 3'(scnt_q - CL_C);
  assign tail_bad   = shift_edge && (scnt_q >= CL_C) &&
                      (bus.ccff_tail != PREAMBLE[3'd7 - tail_idx]);
  assign xfer       = bus.cfg_valid && bus.cfg_ready;

  ccff_byte_serializer u_ser (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .clr     (start_go),
    .en      (busy && (acc_q < NB_C)),
    .data    (bus.cfg_data),
    .valid   (bus.cfg_valid),
    .ready   (bus.cfg_ready),
    .pop     (pop),
    .sbit    (ser_bit),
    .has_bit (has_bit)
  );

  // State register
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_go) state_d = PRE;
      PRE:             if (icnt_q == PL_C - 1'b1) state_d = PAY;
      PAY:             if (last_shift) state_d = (mism_q || tail_bad) ? ERR : DONE;
      default:         state_d = IDLE;
    endcase
  end

  // Outputs (en_d/head_d are the next values of the registered chain signals)
  always_comb begin
    en_d   = 1'b0;
    head_d = bus.ccff_head;
    pop    = 1'b0;
    busy   = (state_q == PRE) || (state_q == PAY);
    done   = (state_q == DONE);
    error  = (state_q == ERR);
    case (state_q)
      PRE: begin
        en_d   = 1'b1;
        head_d = PREAMBLE[3'd7 - icnt_q[2:0]];
      end
      PAY: begin
        // Empty buffer stalls the chain; head holds its last value.
        if (icnt_q < TOT_C && has_bit) begin
          en_d   = 1'b1;
          head_d = ser_bit;
          pop    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      bus.ccff_en   <= 1'b0;
      bus.ccff_head <= 1'b0;
      icnt_q        <= '0;
      scnt_q        <= '0;
      acc_q         <= '0;
      mism_q        <= 1'b0;
    end else begin
      bus.ccff_en   <= en_d;
      bus.ccff_head <= head_d;
      if (start_go) begin
        icnt_q <= '0;
        scnt_q <= '0;
        acc_q  <= '0;
        mism_q <= 1'b0;
      end else begin
        if (en_d && icnt_q < TOT_C)       icnt_q <= icnt_q + 1'b1;
        if (shift_edge && scnt_q < TOT_C) scnt_q <= scnt_q + 1'b1;
        if (tail_bad)                     mism_q <= 1'b1;
        if (xfer)                         acc_q  <= acc_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: 23-flop and 8-flop behavioural chains.
module tb_ccff_loader;
  logic prog_clk = 1'b0, prog_reset = 1'b0, start = 1'b0, start8 = 1'b0;
  logic busy, done, error, busy8, done8, error8;
  int   errors = 0, checks = 0;

  ccff_loader_if bus();
  ccff_loader_if b8();

  ccff_loader #(.CHAIN_LEN(23), .PRE_LEN(8), .PREAMBLE(8'hA5)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error));

  ccff_loader #(.CHAIN_LEN(8), .PRE_LEN(8), .PREAMBLE(8'hA5)) dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start8), .bus(b8),
    .busy(busy8), .done(done8), .error(error8));

  always #5 prog_clk = ~prog_clk;

  // Behavioural chains and monitors
  logic [22:0] chain  = '0;
  logic [7:0]  chain8 = '0;
  logic        stuck5 = 1'b0;
  logic        tails8 [0:63];
  int shifts = 0, xfers = 0, sh8 = 0, xf8 = 0, rdy_after8 = 0, busy_cyc = 0;
  localparam logic [22:0] EXP_CHAIN = 23'b0011_1100_1111_0000_0101_101;

  assign bus.ccff_tail = chain[22];
  assign b8.ccff_tail  = chain8[7];

  always @(posedge prog_clk) begin
    if (bus.ccff_en) begin
      chain  <= stuck5 ? ({chain[21:0], bus.ccff_head} & ~23'h20) : {chain[21:0], bus.ccff_head};
      shifts <= shifts + 1;
    end
    if (bus.cfg_valid && bus.cfg_ready) xfers <= xfers + 1;
    if (b8.ccff_en) begin
      chain8            <= {chain8[6:0], b8.ccff_head};
      tails8[sh8[5:0]]  <= b8.ccff_tail;
      sh8               <= sh8 + 1;
    end
    if (b8.cfg_valid && b8.cfg_ready) xf8 <= xf8 + 1;
  end

  always @(negedge prog_clk) begin
    if (busy) busy_cyc <= busy_cyc + 1;
    if (xf8 > 0 && b8.cfg_ready) rdy_after8 <= rdy_after8 + 1;
  end

  // Byte feeder for the main DUT: offers 4 bytes (the 4th must never be taken),
  // optionally withholding byte 1 for stall_cfg cycles in which ready is high.
  logic [7:0] feed_bytes [0:3] = '{8'h3C, 8'hF0, 8'h5B, 8'hFF};
  int stall_cfg = 0, load_id = 0;
  int seen_id = 0, idx = 0, stall_left = 0;
  bit prev_fire = 1'b0;

  always @(negedge prog_clk) begin
    if (load_id != seen_id) begin
      seen_id = load_id; idx = 0; stall_left = stall_cfg; prev_fire = 1'b0;
    end else if (prev_fire) idx++;
    if (idx == 1 && stall_left > 0) begin
      bus.cfg_valid = 1'b0;
      if (bus.cfg_ready) stall_left--;
    end else if (idx < 4) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = feed_bytes[idx];
    end else bus.cfg_valid = 1'b0;
    prev_fire = bus.cfg_valid && bus.cfg_ready;
  end

  int sh_base, xf_base, bc_base;

  task automatic start_load;
    @(negedge prog_clk);
    sh_base = shifts; xf_base = xfers; bc_base = busy_cyc;
    load_id++;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 400) begin n++; @(negedge prog_clk); end
  endtask

  task automatic test_reset;
    #1 prog_reset = 1'b1;
    b8.cfg_valid = 1'b0; b8.cfg_data = 8'h00;
    #1;
    checks++;
    if ({busy, done, error, bus.ccff_en, bus.ccff_head, bus.cfg_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_main got=%b exp=000000",
        {busy, done, error, bus.ccff_en, bus.ccff_head, bus.cfg_ready});
    end
    checks++;
    if ({busy8, done8, error8, b8.ccff_en, b8.ccff_head, b8.cfg_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_dut8 got=%b exp=000000",
        {busy8, done8, error8, b8.ccff_en, b8.ccff_head, b8.cfg_ready});
    end
    @(negedge prog_clk); @(negedge prog_clk);
    prog_reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    stall_cfg = 0;
    start_load();
    wait_idle();
    checks++; if (shifts - sh_base !== 31) begin errors++; $display("FAIL b2b_shifts got=%0d exp=31", shifts - sh_base); end
    checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL b2b_chain got=%b exp=%b", chain, EXP_CHAIN); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL b2b_done_err got=%b exp=10", {done, error}); end
    checks++; if (xfers - xf_base !== 3) begin errors++; $display("FAIL b2b_xfers got=%0d exp=3", xfers - xf_base); end
    checks++; if (busy_cyc - bc_base !== 34) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=34", busy_cyc - bc_base); end
    checks++; if (bus.ccff_en !== 1'b0) begin errors++; $display("FAIL b2b_en_idle got=%b exp=0", bus.ccff_en); end
  endtask

  task automatic test_stall;
    int n = 0;
    logic held;
    stall_cfg = 20;
    start_load();
    while (shifts - sh_base < 16 && n < 100) begin n++; @(negedge prog_clk); end
    held = bus.ccff_head;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.ccff_en, bus.ccff_head} !== {1'b0, held}) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%b exp=%b", i, {bus.ccff_en, bus.ccff_head}, {1'b0, held});
      end
      @(negedge prog_clk);
    end
    wait_idle();
    stall_cfg = 0;
    checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL stall_chain got=%b exp=%b", chain, EXP_CHAIN); end
    checks++; if (shifts - sh_base !== 31) begin errors++; $display("FAIL stall_shifts got=%0d exp=31", shifts - sh_base); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL stall_done_err got=%b exp=10", {done, error}); end
    checks++; if (busy_cyc - bc_base !== 54) begin errors++; $display("FAIL stall_busy_cycles got=%0d exp=54", busy_cyc - bc_base); end
  endtask

  task automatic test_stuck_bit;
    stuck5 = 1'b1;
    start_load();
    wait_idle();
    stuck5 = 1'b0;
    checks++; if ({done, error} !== 2'b01) begin errors++; $display("FAIL stuck_done_err got=%b exp=01", {done, error}); end
    checks++; if (shifts - sh_base !== 31) begin errors++; $display("FAIL stuck_shifts got=%0d exp=31", shifts - sh_base); end
    checks++; if (busy_cyc - bc_base !== 34) begin errors++; $display("FAIL stuck_busy_cycles got=%0d exp=34", busy_cyc - bc_base); end
  endtask

  task automatic test_reset_midload;
    int n = 0;
    start_load();
    while (shifts - sh_base < 12 && n < 100) begin n++; @(negedge prog_clk); end
    prog_reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, bus.ccff_en, bus.ccff_head, bus.cfg_ready} !== 6'b0) begin
      errors++; $display("FAIL midreset_outputs got=%b exp=000000",
        {busy, done, error, bus.ccff_en, bus.ccff_head, bus.cfg_ready});
    end
    @(negedge prog_clk);
    prog_reset = 1'b0;
    start_load();
    wait_idle();
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL midreset_done_err got=%b exp=10", {done, error}); end
    checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL midreset_chain got=%b exp=%b", chain, EXP_CHAIN); end
    checks++; if (shifts - sh_base !== 31) begin errors++; $display("FAIL midreset_shifts got=%0d exp=31", shifts - sh_base); end
  endtask

  task automatic test_start_while_busy;
    int  n = 0;
    bit  pulsed = 1'b0;
    start_load();
    while (busy && n < 400) begin
      if (!pulsed && shifts - sh_base == 15) begin start = 1'b1; pulsed = 1'b1; end
      else start = 1'b0;
      n++;
      @(negedge prog_clk);
    end
    start = 1'b0;
    checks++; if (shifts - sh_base !== 31) begin errors++; $display("FAIL restart_shifts got=%0d exp=31", shifts - sh_base); end
    checks++; if (xfers - xf_base !== 3) begin errors++; $display("FAIL restart_xfers got=%0d exp=3", xfers - xf_base); end
    checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL restart_chain got=%b exp=%b", chain, EXP_CHAIN); end
    checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL restart_done_err got=%b exp=10", {done, error}); end
    checks++; if (busy_cyc - bc_base !== 34) begin errors++; $display("FAIL restart_busy_cycles got=%0d exp=34", busy_cyc - bc_base); end
  endtask

  task automatic test_chain8;
    int n = 0;
    logic [7:0] got;
    @(negedge prog_clk);
    b8.cfg_valid = 1'b1; b8.cfg_data = 8'h81; start8 = 1'b1;
    @(negedge prog_clk);
    start8 = 1'b0;
    while (busy8 && n < 200) begin n++; @(negedge prog_clk); end
    b8.cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) got[7-i] = tails8[8+i];
    checks++; if (sh8 !== 16) begin errors++; $display("FAIL c8_shifts got=%0d exp=16", sh8); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL c8_tail_preamble got=%h exp=a5", got); end
    checks++; if (chain8 !== 8'h81) begin errors++; $display("FAIL c8_chain got=%h exp=81", chain8); end
    checks++; if ({done8, error8} !== 2'b10) begin errors++; $display("FAIL c8_done_err got=%b exp=10", {done8, error8}); end
    checks++; if (xf8 !== 1) begin errors++; $display("FAIL c8_xfers got=%0d exp=1", xf8); end
    checks++; if (rdy_after8 !== 0) begin errors++; $display("FAIL c8_ready_after got=%0d exp=0", rdy_after8); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_stuck_bit();
    test_reset_midload();
    test_start_while_busy();
    test_chain8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
